debug_sequencer: RTL

Sequences host debug commands onto the CPU's debug datapath. It halts the core, issues one 4-bit debug op per command to the debug decoder, and runs the memory bus handshake. It also owns the auto-incrementing debug address register and returns one response word per command. It sits between the debug-port command deframer and the debug decoder, register file and bus sequencer.

---
 rtl/debug_sequencer_if.sv | 48 ++++
 rtl/debug_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : debug_sequencer_if
// Description : Bundles the command, halt, debug-decoder, bus and response
//               signals of the debug sequencer.
//               master : sequencer side (drives ready/halt/op/bus/rsp)
//               slave  : environment side (deframer, core, datapath, host)
//               Ports: cmd_valid/ready/op/arg/data, halt_req/halted,
//               debug_op/argx/addr/wdata, bus_req/ack, rd_data,
//               rsp_valid/ready/data/err.
// Revision    : 1.0 - initial release
// ============================================================================
interface debug_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [3:0]        cmd_arg;
  logic [DATA_W-1:0] cmd_data;
  logic              halt_req;
  logic              halted;
  logic [3:0]        debug_op;
  logic [3:0]        debug_argx;
  logic [ADDR_W-1:0] debug_addr;
  logic [DATA_W-1:0] debug_wdata;
  logic              bus_req;
  logic              bus_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_arg, cmd_data, halted, bus_ack, rd_data, rsp_ready,
    output cmd_ready, halt_req, debug_op, debug_argx, debug_addr, debug_wdata,
           bus_req, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_arg, cmd_data, halted, bus_ack, rd_data, rsp_ready,
    input  cmd_ready, halt_req, debug_op, debug_argx, debug_addr, debug_wdata,
           bus_req, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/debug_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : debug_sequencer
// Description : Turns host debug commands into halt requests, one debug op
//               per command, and memory bus handshakes; owns the
//               auto-incrementing debug address and returns one response
//               word per command.
//               Ports: clk, rst_n (async, active-low), dbg (master modport
//               of debug_sequencer_if).
//               Optional feature: define DEBUG_SEQ_TIMEOUT_EN to abandon
//               halt/bus waits after TIMEOUT cycles with RSP_ERR=1.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  debug_sequencer_if.master dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_ISSUE     = 3'd2,
    S_BUS_WAIT  = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_RD_REG  = 3'd1;
  localparam logic [2:0] OP_RD_MEM  = 3'd4;
  localparam logic [2:0] OP_WR_MEM  = 3'd5;
  localparam logic [2:0] OP_LD_ADDR = 3'd6;
  localparam logic [2:0] OP_RESUME  = 3'd7;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [3:0]        arg_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cmd_ready_q;
  logic              halt_req_q;
  logic              bus_req_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [3:0]        debug_op_q;
  logic [3:0]        debug_argx_q;
  logic              inc_en;
  logic              is_mem_op;
  logic              expired;

  // Only register reads and memory accesses advance the address.
  assign inc_en    = op_q[0] && (op_q[3:1] == OP_RD_REG || op_q[3:1] == OP_RD_MEM ||
                                 op_q[3:1] == OP_WR_MEM);
  assign is_mem_op = (op_q[3:1] == OP_RD_MEM) || (op_q[3:1] == OP_WR_MEM);

`ifdef DEBUG_SEQ_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q;
  logic             rsp_err_q;

  // Counts consecutive cycles spent in a wait state; cleared everywhere else,
  // so each wait starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state_q == S_HALT_WAIT || state_q == S_BUS_WAIT) begin
      timer_q <= timer_q + TMR_W'(1);
    end else begin
      timer_q <= '0;
    end
  end

  assign expired     = (timer_q == TMR_LAST);
  assign dbg.rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign expired        = 1'b0;
  assign dbg.rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      arg_q        <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      cmd_ready_q  <= 1'b0;
      halt_req_q   <= 1'b0;
      bus_req_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      debug_op_q   <= '0;
      debug_argx_q <= '0;
`ifdef DEBUG_SEQ_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (dbg.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            op_q        <= dbg.cmd_op;
            arg_q       <= dbg.cmd_arg;
            data_q      <= dbg.cmd_data;
            case (dbg.cmd_op[3:1])
              OP_NONE: begin
                rsp_data_q  <= '0;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              OP_LD_ADDR: begin
                addr_q      <= ADDR_W'(dbg.cmd_data);
                rsp_data_q  <= dbg.cmd_data;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              OP_RESUME: begin
                halt_req_q  <= 1'b0;
                rsp_data_q  <= '0;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              default: begin
                halt_req_q <= 1'b1;
                // Already halted: skip the wait and present the op next cycle.
                if (dbg.halted) begin
                  debug_op_q   <= dbg.cmd_op;
                  debug_argx_q <= dbg.cmd_arg;
                  state_q      <= S_ISSUE;
                end else begin
                  state_q <= S_HALT_WAIT;
                end
              end
            endcase
          end
        end

        S_HALT_WAIT: begin
          if (dbg.halted) begin
            debug_op_q   <= op_q;
            debug_argx_q <= arg_q;
            state_q      <= S_ISSUE;
          end else if (expired) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
`ifdef DEBUG_SEQ_TIMEOUT_EN
            rsp_err_q   <= 1'b1;
`endif
          end
        end

        S_ISSUE: begin
          if (is_mem_op) begin
            bus_req_q <= 1'b1;
            state_q   <= S_BUS_WAIT;
          end else begin
            debug_op_q   <= '0;
            debug_argx_q <= '0;
            rsp_data_q   <= dbg.rd_data;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
            if (inc_en) addr_q <= addr_q + ADDR_W'(1);
          end
        end

        S_BUS_WAIT: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (dbg.bus_ack) begin
            bus_req_q    <= 1'b0;
            debug_op_q   <= '0;
            debug_argx_q <= '0;
            rsp_data_q   <= (op_q[3:1] == OP_RD_MEM) ? dbg.rd_data : data_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
            if (inc_en) addr_q <= addr_q + ADDR_W'(1);
          end else if (expired) begin
            bus_req_q    <= 1'b0;
            debug_op_q   <= '0;
            debug_argx_q <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
`ifdef DEBUG_SEQ_TIMEOUT_EN
            rsp_err_q    <= 1'b1;
`endif
          end
        end

        S_RESP: begin
          if (dbg.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
`ifdef DEBUG_SEQ_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg.cmd_ready   = cmd_ready_q;
  assign dbg.halt_req    = halt_req_q;
  assign dbg.debug_op    = debug_op_q;
  assign dbg.debug_argx  = debug_argx_q;
  assign dbg.debug_addr  = addr_q;
  assign dbg.debug_wdata = data_q;
  assign dbg.bus_req     = bus_req_q;
  assign dbg.rsp_valid   = rsp_valid_q;
  assign dbg.rsp_data    = rsp_data_q;

endmodule
`default_nettype wire
